// File: rtl/overlap_accum_seq.sv
// Serial GF(2) overlap-add of NPP partial products at SHIFT-bit offsets into an OW-bit result.
// Optional OVERLAP_ACCUM_RESYNC_EN adds in_first/err so a new frame can restart a partial one.
module overlap_accum_seq #(
    parameter int  W     = 11,
    parameter int  SHIFT = 6,
    parameter int  NPP   = 3,
    localparam int OW    = (NPP - 1) * SHIFT + W,
    localparam int IW    = (NPP > 2) ? $clog2(NPP) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
`ifdef OVERLAP_ACCUM_RESYNC_EN
    input  logic          in_first,
    output logic          err,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          busy
);

    if (W < 2 || W > 256 || SHIFT < 1 || SHIFT > W || NPP < 2 || NPP > 16) begin : g_param_check
        $error("overlap_accum_seq: illegal W/SHIFT/NPP combination");
    end

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t        state, state_n;
    logic [OW-1:0] acc, acc_n;
    logic [IW-1:0] idx, idx_n;
    logic [OW-1:0] word_ext;
    logic [OW-1:0] word_sh;
    logic          accept;
    logic          last;
    logic          resync;

    assign word_ext = {{(OW - W){1'b0}}, in_data};
    assign word_sh  = word_ext << (idx * SHIFT);
    assign accept   = in_valid && in_ready;
    assign last     = (idx == IW'(NPP - 1));

`ifdef OVERLAP_ACCUM_RESYNC_EN
    assign resync = in_first && (idx != '0);
`else
    assign resync = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            idx   <= '0;
`ifdef OVERLAP_ACCUM_RESYNC_EN
            err   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            acc   <= acc_n;
            idx   <= idx_n;
`ifdef OVERLAP_ACCUM_RESYNC_EN
            err   <= accept && resync;
`endif
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        idx_n   = idx;
        case (state)
            ACCUM: begin
                if (accept) begin
                    // A restarted frame drops the partial sum and takes this word as its offset-0 term.
                    if (resync) begin
                        acc_n = word_ext;
                        idx_n = IW'(1);
                    end else begin
                        acc_n = acc ^ word_sh;
                        if (last) begin
                            idx_n   = '0;
                            state_n = HOLD;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_n   = '0;
                    state_n = ACCUM;
                end
            end
            default: state_n = ACCUM;
        endcase
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign out_data  = acc;
    assign busy      = (idx != '0) || (state == HOLD);

endmodule
